// File: rtl/core_pkg.sv
// Shared constants for the mriscv multi-cycle sequencer: state codes, reset PC
// and the instruction-class priority used when decoder flags overlap.
package core_pkg;

   localparam logic [2:0] S_FETCH     = 3'd0;
   localparam logic [2:0] S_DECODE    = 3'd1;
   localparam logic [2:0] S_EXECUTE   = 3'd2;
   localparam logic [2:0] S_MEMORY    = 3'd3;
   localparam logic [2:0] S_WRITEBACK = 3'd4;
   localparam logic [2:0] S_HALT      = 3'd5;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   localparam logic [2:0] CLS_NONE   = 3'd0;
   localparam logic [2:0] CLS_LOAD   = 3'd1;
   localparam logic [2:0] CLS_STORE  = 3'd2;
   localparam logic [2:0] CLS_JUMP   = 3'd3;
   localparam logic [2:0] CLS_BRANCH = 3'd4;
   localparam logic [2:0] CLS_ALU    = 3'd5;

   // Collapse the decoder flags to one class: load > store > jump > branch > reg/alu.
   function automatic logic [2:0] classify(input logic ld, input logic st,
                                           input logic jmp, input logic br,
                                           input logic rg, input logic alu);
      logic [2:0] cls;
      cls = CLS_NONE;
      if (ld)             cls = CLS_LOAD;
      else if (st)        cls = CLS_STORE;
      else if (jmp)       cls = CLS_JUMP;
      else if (br)        cls = CLS_BRANCH;
      else if (rg || alu) cls = CLS_ALU;
      return cls;
   endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Wait counter shared by the fetch and data handshakes; flags a request that
// has waited TIMEOUT cycles without ack. An ack in that same cycle wins.
module bus_watchdog #(
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic req,
   input  logic ack,
   output logic timeout
);

   localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

   logic [7:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (start || (req && ack)) begin
         count <= '0;
      end else if (req && (count != LIMIT)) begin
         count <= count + 8'd1;
      end
   end

   assign timeout = req && !ack && (count == LIMIT);

endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer for mriscv.
// Optional retire counter on perf_instret is built when CORE_CTRL_PERF_EN is defined.
module core_ctrl
   import core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          TIMEOUT  = 255
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   input  logic        is_load,
   input  logic        is_store,
   input  logic        is_branch,
   input  logic        is_jump,
   input  logic        is_reg,
   input  logic        is_alu,
   input  logic [4:0]  dest,
   input  logic [31:0] branch_dest,
   input  logic        branch_taken,
   input  logic [31:0] alu_result,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        rf_w_en,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pc,
   output logic        trap,
   output logic [31:0] perf_instret,
   output logic [2:0]  state
);

   // Handshake: a req is raised by this block and held until the cycle its
   // ack is seen; ack is only honoured while req is high, and req drops the
   // cycle after. Reset or a watchdog trip drops req without waiting.

   logic [2:0]  cls;
   logic [2:0]  held_cls;
   logic [31:0] result;
   logic [31:0] pc_plus4;
   logic [31:0] branch_next;
   logic        target_bad;
   logic        wd_start;
   logic        wd_req;
   logic        wd_ack;
   logic        wd_timeout;

   assign cls         = classify(is_load, is_store, is_jump, is_branch, is_reg, is_alu);
   assign pc_plus4    = pc + 32'd4;
   assign branch_next = branch_taken ? branch_dest : pc_plus4;
   assign target_bad  = (branch_dest[1:0] != 2'b00) &&
                        ((cls == CLS_JUMP) || ((cls == CLS_BRANCH) && branch_taken));

   assign imem_addr = pc;
   assign rf_wdata  = result;

   // Fetch and data phases never overlap, so one counter serves both.
   assign wd_start = (state != S_FETCH) && (state != S_MEMORY);
   assign wd_req   = imem_req || dmem_req;
   assign wd_ack   = (imem_req && imem_ack) || (dmem_req && dmem_ack);

   bus_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .start   (wd_start),
      .req     (wd_req),
      .ack     (wd_ack),
      .timeout (wd_timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         instr    <= '0;
         result   <= '0;
         held_cls <= CLS_NONE;
         imem_req <= 1'b0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         rf_w_en  <= 1'b0;
         rf_waddr <= '0;
         trap     <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (!imem_req) begin
                  imem_req <= 1'b1;
               end else if (imem_ack) begin
                  instr    <= imem_rdata;
                  imem_req <= 1'b0;
                  state    <= S_DECODE;
               end else if (wd_timeout) begin
                  imem_req <= 1'b0;
                  trap     <= 1'b1;
                  state    <= S_HALT;
               end
            end
            S_DECODE: begin
               state <= S_EXECUTE;
            end
            S_EXECUTE: begin
               held_cls <= cls;
               if ((cls == CLS_NONE) || target_bad) begin
                  trap  <= 1'b1;
                  state <= S_HALT;
               end else begin
                  case (cls)
                     CLS_LOAD, CLS_STORE: begin
                        dmem_req <= 1'b1;
                        dmem_we  <= (cls == CLS_STORE);
                        state    <= S_MEMORY;
                     end
                     CLS_JUMP: begin
                        result   <= pc_plus4;
                        pc       <= branch_dest;
                        rf_w_en  <= (dest != 5'd0);
                        rf_waddr <= dest;
                        state    <= S_WRITEBACK;
                     end
                     CLS_BRANCH: begin
                        pc       <= branch_next;
                        imem_req <= 1'b1;
                        state    <= S_FETCH;
                     end
                     default: begin
                        result   <= alu_result;
                        rf_w_en  <= (dest != 5'd0);
                        rf_waddr <= dest;
                        state    <= S_WRITEBACK;
                     end
                  endcase
               end
            end
            S_MEMORY: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  if (held_cls == CLS_STORE) begin
                     pc       <= pc_plus4;
                     imem_req <= 1'b1;
                     state    <= S_FETCH;
                  end else begin
                     result   <= dmem_rdata;
                     rf_w_en  <= (dest != 5'd0);
                     rf_waddr <= dest;
                     state    <= S_WRITEBACK;
                  end
               end else if (wd_timeout) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  trap     <= 1'b1;
                  state    <= S_HALT;
               end
            end
            S_WRITEBACK: begin
               rf_w_en <= 1'b0;
               // A jump already loaded its target in EXECUTE.
               if (held_cls != CLS_JUMP) pc <= pc_plus4;
               imem_req <= 1'b1;
               state    <= S_FETCH;
            end
            default: begin
               imem_req <= 1'b0;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
               rf_w_en  <= 1'b0;
               state    <= S_HALT;
            end
         endcase
      end
   end

`ifdef CORE_CTRL_PERF_EN
   logic        retire;
   logic [31:0] instret;

   assign retire = ((state == S_EXECUTE) && (cls == CLS_BRANCH) && !target_bad) ||
                   ((state == S_MEMORY) && dmem_ack && (held_cls == CLS_STORE)) ||
                   (state == S_WRITEBACK);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         instret <= '0;
      end else if (retire) begin
         instret <= instret + 32'd1;
      end
   end

   assign perf_instret = instret;
`else
   assign perf_instret = '0;
`endif

endmodule

// File: tb/tb_core_ctrl.sv
// Bench for core_ctrl: a table of instructions run back to back from reset,
// then hand-written trap, timeout and reset-during-handshake sequences.
module tb_core_ctrl;
   import core_pkg::*;

`ifdef CORE_CTRL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [5:0] F_LD  = 6'b100000;
   localparam logic [5:0] F_ST  = 6'b010000;
   localparam logic [5:0] F_JMP = 6'b001000;
   localparam logic [5:0] F_BR  = 6'b000100;
   localparam logic [5:0] F_RG  = 6'b000010;
   localparam logic [5:0] F_ALU = 6'b000001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] instr;
   logic        is_load = 1'b0, is_store = 1'b0, is_branch = 1'b0;
   logic        is_jump = 1'b0, is_reg = 1'b0, is_alu = 1'b0;
   logic [4:0]  dest = '0;
   logic [31:0] branch_dest = '0;
   logic        branch_taken = 1'b0;
   logic [31:0] alu_result = '0;
   logic        dmem_req;
   logic        dmem_we;
   logic        dmem_ack = 1'b0;
   logic [31:0] dmem_rdata = '0;
   logic        rf_w_en;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pc;
   logic        trap;
   logic [31:0] perf_instret;
   logic [2:0]  state;

   core_ctrl dut (
      .clk(clk), .reset(reset),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr),
      .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
      .is_jump(is_jump), .is_reg(is_reg), .is_alu(is_alu),
      .dest(dest), .branch_dest(branch_dest), .branch_taken(branch_taken), .alu_result(alu_result),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .rf_w_en(rf_w_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pc(pc), .trap(trap), .perf_instret(perf_instret), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  flags;
      logic [4:0]  dest;
      logic [31:0] bdest;
      logic        taken;
      logic [31:0] alu_res;
      logic [31:0] drdata;
      int          imem_dly;
      int          dmem_dly;
      logic        exp_wr;
      logic [4:0]  exp_waddr;
      logic [31:0] exp_wdata;
      logic        exp_mem;
      logic        exp_we;
      logic [31:0] exp_pc;
   } vec_t;

   int          n_vec = 0;
   int          n_fail = 0;
   logic [36:0] exp_q[$];
   logic [36:0] wr_exp;
   vec_t        vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [5:0] fl, input logic [4:0] d, input logic [31:0] bd,
                               input logic tk, input logic [31:0] ar, input logic [31:0] dr,
                               input logic ew, input logic [4:0] ea, input logic [31:0] ed,
                               input logic em, input logic ewe, input logic [31:0] ep);
      vec_t v;
      v.flags = fl; v.dest = d; v.bdest = bd; v.taken = tk; v.alu_res = ar; v.drdata = dr;
      v.imem_dly = $urandom_range(0, 3);
      v.dmem_dly = $urandom_range(0, 2);
      v.exp_wr = ew; v.exp_waddr = ea; v.exp_wdata = ed;
      v.exp_mem = em; v.exp_we = ewe; v.exp_pc = ep;
      return v;
   endfunction

   task automatic set_inputs(input vec_t v);
      {is_load, is_store, is_jump, is_branch, is_reg, is_alu} = v.flags;
      dest = v.dest; branch_dest = v.bdest; branch_taken = v.taken;
      alu_result = v.alu_res; dmem_rdata = v.drdata;
   endtask

   // Reset is held across two falling edges; all outputs must be at reset values.
   task automatic apply_reset(input string tag);
      reset = 1'b1;
      imem_ack = 1'b0;
      dmem_ack = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check({tag, "_state"}, 32'(state), 32'(S_FETCH));
      check({tag, "_pc"}, pc, 32'h0);
      check({tag, "_instr"}, instr, 32'h0);
      check_bit({tag, "_imem_req"}, imem_req, 1'b0);
      check_bit({tag, "_dmem_req"}, dmem_req, 1'b0);
      check_bit({tag, "_dmem_we"}, dmem_we, 1'b0);
      check_bit({tag, "_rf_w_en"}, rf_w_en, 1'b0);
      check({tag, "_rf_waddr"}, 32'(rf_waddr), 32'h0);
      check({tag, "_rf_wdata"}, rf_wdata, 32'h0);
      check_bit({tag, "_trap"}, trap, 1'b0);
      check({tag, "_perf"}, perf_instret, 32'h0);
      reset = 1'b0;
   endtask

   task automatic do_fetch(input int dly, input string tag);
      int t;
      logic [31:0] word;
      t = 0;
      while (!imem_req && t < 50) begin
         @(negedge clk);
         t++;
      end
      check_bit({tag, "_imem_req"}, imem_req, 1'b1);
      repeat (dly) @(negedge clk);
      word = $urandom;
      imem_rdata = word;
      imem_ack = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      check({tag, "_instr"}, instr, word);
   endtask

   task automatic wait_trap(input int budget, input string tag);
      int t;
      t = 0;
      while (!trap && t < budget) begin
         @(negedge clk);
         t++;
      end
      check_bit({tag, "_trap"}, trap, 1'b1);
      check({tag, "_state"}, 32'(state), 32'(S_HALT));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      int t;
      int n;
      set_inputs(v);
      if (v.exp_wr) exp_q.push_back({v.exp_waddr, v.exp_wdata});
      do_fetch(v.imem_dly, tag);
      if (v.exp_mem) begin
         t = 0;
         while (!dmem_req && t < 20) begin
            @(negedge clk);
            t++;
         end
         n = 0;
         for (int k = 0; k <= v.dmem_dly; k++) begin
            if (dmem_req) n++;
            if (k == 0) check_bit({tag, "_dmem_we"}, dmem_we, v.exp_we);
            if (k == v.dmem_dly) dmem_ack = 1'b1;
            @(negedge clk);
         end
         dmem_ack = 1'b0;
         if (dmem_req) n++;
         check({tag, "_dmem_req_cycles"}, 32'(n), 32'(v.dmem_dly + 1));
      end
      t = 0;
      while (!(imem_req && state == S_FETCH) && t < 20) begin
         @(negedge clk);
         t++;
      end
      check({tag, "_next_fetch_addr"}, imem_addr, v.exp_pc);
   endtask

   // Register-file write scoreboard: every rf_w_en cycle must match the queue head.
   always @(negedge clk) begin
      if (!reset && rf_w_en) begin
         n_vec++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rf_write: unexpected write x%0d=%h, none expected", rf_waddr, rf_wdata);
         end else begin
            wr_exp = exp_q.pop_front();
            if ({rf_waddr, rf_wdata} !== wr_exp) begin
               n_fail++;
               $display("FAIL rf_write: got x%0d=%h expected x%0d=%h",
                        rf_waddr, rf_wdata, wr_exp[36:32], wr_exp[31:0]);
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL global_timeout: got no finish expected finish before time limit");
      $fatal(1, "simulation time limit reached");
   end

   initial begin
      int n;
      int t;
      logic [31:0] rnd;
      vec_t v;

      rnd = $urandom;
      //             flags        dest bdest          tk ar           drdata        wr ea  ed            mem we  next pc
      vecs[0]  = mk(F_ALU,        5,  32'h0,         0, 32'd7,       32'h0,        1, 5,  32'd7,        0, 0, 32'h4);
      vecs[1]  = mk(F_LD,         2,  32'h0,         0, 32'h1000,    32'hDEADBEEF, 1, 2,  32'hDEADBEEF, 1, 0, 32'h8);
      vecs[2]  = mk(F_BR,         0,  32'h40,        1, 32'h0,       32'h0,        0, 0,  32'h0,        0, 0, 32'h40);
      vecs[3]  = mk(F_BR,         0,  32'h80,        0, 32'h0,       32'h0,        0, 0,  32'h0,        0, 0, 32'h44);
      vecs[4]  = mk(F_JMP,        1,  32'h100,       0, 32'h0,       32'h0,        1, 1,  32'h48,       0, 0, 32'h100);
      vecs[5]  = mk(F_JMP,        0,  32'h200,       0, 32'h0,       32'h0,        0, 0,  32'h0,        0, 0, 32'h200);
      vecs[6]  = mk(F_ST,         9,  32'h0,         0, 32'h1000,    32'h0,        0, 0,  32'h0,        1, 1, 32'h204);
      vecs[7]  = mk(F_RG,         0,  32'h0,         0, 32'h77,      32'h0,        0, 0,  32'h0,        0, 0, 32'h208);
      vecs[8]  = mk(F_LD | F_ST,  3,  32'h0,         0, 32'h0,       32'h55,       1, 3,  32'h55,       1, 0, 32'h20C);
      vecs[9]  = mk(F_JMP | F_BR, 4,  32'h300,       0, 32'h0,       32'h0,        1, 4,  32'h210,      0, 0, 32'h300);
      vecs[10] = mk(F_RG | F_ALU, 7,  32'h0,         0, rnd,         32'h0,        1, 7,  rnd,          0, 0, 32'h304);
      vecs[11] = mk(F_BR | F_ALU, 8,  32'h400,       1, 32'h99,      32'h0,        0, 0,  32'h0,        0, 0, 32'h400);
      vecs[12] = mk(F_JMP,        10, 32'hFFFF_FFFC, 0, 32'h0,       32'h0,        1, 10, 32'h404,      0, 0, 32'hFFFF_FFFC);
      vecs[13] = mk(F_ALU,        11, 32'h0,         0, 32'd1,       32'h0,        1, 11, 32'd1,        0, 0, 32'h0);
      vecs[1].dmem_dly = 3;
      vecs[8].dmem_dly = 0;

      apply_reset("reset0");
      for (int i = 0; i < 14; i++) run_vec(vecs[i], $sformatf("v%0d", i));
      check("perf_after_table", perf_instret, PERF ? 32'd14 : 32'd0);

      // Illegal instruction: no class flag set.
      v = mk(6'b0, 0, 32'h0, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
      set_inputs(v);
      do_fetch(1, "illegal");
      wait_trap(10, "illegal");
      repeat (3) @(negedge clk);
      check_bit("illegal_imem_req_held_low", imem_req, 1'b0);
      check("illegal_pc_frozen", pc, 32'h0);
      check("illegal_perf_frozen", perf_instret, PERF ? 32'd14 : 32'd0);

      // Misaligned target: ignored when not taken, traps when taken.
      apply_reset("reset1");
      v = mk(F_BR, 0, 32'h42, 0, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h4);
      run_vec(v, "misaligned_not_taken");
      v = mk(F_BR, 0, 32'h42, 1, 32'h0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h4);
      set_inputs(v);
      do_fetch(0, "misaligned_taken");
      wait_trap(10, "misaligned_taken");
      check("misaligned_taken_pc", pc, 32'h4);

      // Ack on the last allowed cycle wins over the timeout.
      apply_reset("reset2");
      v = mk(F_ALU, 6, 32'h0, 0, 32'h1234, 32'h0, 1, 6, 32'h1234, 0, 0, 32'h4);
      v.imem_dly = 254;
      run_vec(v, "ack_at_limit");
      check_bit("ack_at_limit_no_trap", trap, 1'b0);

      // Fetch never acked: request must stay up exactly 255 cycles, then trap.
      n = 0;
      t = 0;
      while (!trap && t < 400) begin
         if (imem_req) n++;
         @(negedge clk);
         t++;
      end
      check("timeout_req_cycles", 32'(n), 32'd255);
      wait_trap(1, "timeout");
      check_bit("timeout_imem_req", imem_req, 1'b0);
      check("timeout_pc", pc, 32'h4);

      // Reset in the middle of a data access drops the request at once.
      apply_reset("reset3");
      v = mk(F_LD, 2, 32'h0, 0, 32'h0, 32'h1111, 0, 0, 32'h0, 0, 0, 32'h0);
      set_inputs(v);
      do_fetch(0, "mid_mem");
      t = 0;
      while (!dmem_req && t < 20) begin
         @(negedge clk);
         t++;
      end
      check_bit("mid_mem_dmem_req_before", dmem_req, 1'b1);
      #2 reset = 1'b1;
      dmem_ack = 1'b1;
      #1;
      check_bit("mid_mem_dmem_req_dropped", dmem_req, 1'b0);
      check("mid_mem_state", 32'(state), 32'(S_FETCH));
      check("mid_mem_perf", perf_instret, 32'h0);
      @(negedge clk);
      dmem_ack = 1'b0;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_mem_after_state", 32'(state), 32'(S_FETCH));
      check_bit("mid_mem_after_imem_req", imem_req, 1'b1);
      check_bit("mid_mem_after_dmem_req", dmem_req, 1'b0);

      check("write_queue_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
Multi-cycle sequencer for the mriscv core. It steps one instruction at a time through fetch, decode, execute, memory and writeback. Along the way it drives the instruction and data memory request/ack handshakes, owns the PC and the instruction register feeding instr_decode, and gates the single write port of regs. It sits between the memories and the instr_decode/ALU/regs datapath.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
TIMEOUT, 255, cycles a memory request may wait for ack before trapping (1..255).

Ports:
clk  input  1  core clock, rising edge.
reset  input  1  asynchronous, active-high reset.
imem_req  output  1  instruction fetch request.
imem_addr  output  32  fetch address, equal to pc.
imem_ack  input  1  fetch data valid this cycle.
imem_rdata  input  32  fetched word.
instr  output  32  instruction register, to instr_decode.
is_load, is_store, is_branch, is_jump, is_reg, is_alu  input  1 each  class flags from instr_decode.
dest  input  5  rd from instr_decode.
branch_dest  input  32  jump/branch target from instr_decode.
branch_taken  input  1  branch condition from ALU.
alu_result  input  32  ALU result; also the data memory address.
dmem_req  output  1  data access request.
dmem_we  output  1  1 = store.
dmem_ack  input  1  data access complete.
dmem_rdata  input  32  load data.
rf_w_en  output  1  to regs w_en.
rf_waddr  output  5  to regs waddr.
rf_wdata  output  32  to regs wdata.
pc  output  32  current PC.
trap  output  1  sticky fault flag.
perf_instret  output  32  retired-instruction count (see Optional Feature).

Behaviour:
- Reset (async): state=FETCH, pc=RESET_PC, instr=0, result reg=0. Outputs: imem_req=0, dmem_req=0, dmem_we=0, rf_w_en=0, rf_waddr=0, rf_wdata=0, trap=0, perf_instret=0. Reset asserted mid-handshake drops req immediately; the pending ack is ignored.
- Encoding: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALT=5.
- FETCH: imem_req=1 held until imem_ack. On ack, instr<=imem_rdata and go to DECODE. req deasserts the cycle after ack.
- DECODE: one cycle for the registered decoder outputs to settle. Always go to EXECUTE.
- EXECUTE: sample flags. Priority when several are set: load > store > jump > branch > reg/alu.
  - No flag set: trap=1, go to HALT.
  - load/store: go to MEMORY.
  - jump: result<=pc+4, pc<=branch_dest, go to WRITEBACK.
  - branch: pc<=branch_taken ? branch_dest : pc+4, retire, go to FETCH.
  - reg/alu: result<=alu_result, go to WRITEBACK.
  - Any taken target with branch_dest[1:0]!=0: trap, go to HALT, pc unchanged.
- MEMORY: dmem_req=1 and dmem_we=is_store, held until dmem_ack.
  - Store: pc<=pc+4, retire, go to FETCH.
  - Load: result<=dmem_rdata, go to WRITEBACK.
- WRITEBACK: rf_w_en=1 for exactly one cycle, rf_waddr=dest, rf_wdata=result. If dest==0, rf_w_en stays 0. pc<=pc+4 unless the instruction was a jump. Retire, go to FETCH.
- Timeout: a counter clears on entry to FETCH/MEMORY and increments each cycle req is high without ack. Reaching TIMEOUT sets trap and goes to HALT with req dropped. An ack in the same cycle as TIMEOUT wins; no trap.
- HALT: all reqs and rf_w_en held at 0, pc frozen. Only reset exits.
- Arithmetic: pc+4 is 32-bit and wraps modulo 2^32 at 32'hFFFF_FFFC -> 0.
- CPI: 3 + fetch wait for branches; 4 + waits for ALU ops, jumps and stores; 5 + waits for loads.

Optional Feature:
CORE_CTRL_PERF_EN
- Defined: perf_instret increments by 1 on every retire (branch, store, writeback exit), wrapping at 2^32. It is cleared by reset and frozen in HALT.
- Undefined: the port stays present and is tied to 0; no counter logic is generated.

Decomposition:
- Package core_pkg: state encoding constants, RESET_PC default, instruction-class priority constants.
- Sub-module bus_watchdog: 8-bit wait counter with start/req/ack inputs and a timeout output. It is instantiated once and shared between fetch and data phases, since they are mutually exclusive.

Test Plan:
- Reset, ack tied 1, instr=ADDI (is_alu, dest=5, alu_result=7) -> pc=0, then 4 cycles later rf_w_en=1, waddr=5, wdata=7, pc=4.
- Load, dmem_ack delayed 3 cycles, dmem_rdata=32'hDEADBEEF, dest=2 -> dmem_req high 4 cycles, dmem_we=0, regs x2 written 32'hDEADBEEF.
- Branch, pc=8, branch_taken=1, branch_dest=32'h40 -> next imem_addr=32'h40, rf_w_en never asserts; with taken=0 -> imem_addr=12.
- JAL, pc=16, dest=1, branch_dest=32'h100 -> x1=20, pc=32'h100; with dest=0 -> no write.
- Illegal instruction (no flags set), and separately imem_ack never asserted -> trap=1, state=HALT. The timeout case traps after exactly 255 cycles of req. Reset clears trap, pc=RESET_PC.
- With CORE_CTRL_PERF_EN defined: 5 mixed instructions -> perf_instret=5. Reset asserted mid-MEMORY -> dmem_req=0 same cycle, perf_instret=0.
